// File: rtl/dual_port_reg_file.sv
// Two-port general-purpose register file with registered reads, write-first bypass
// between ports, a registered Z-pointer view and sticky protocol-error flags.

module dprf_port #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] rd_val,
  output logic                  is_wr,
  output logic                  is_ill,
  output logic                  drive_q,
  output logic [DATA_WIDTH-1:0] latch_q
);
  logic                  is_rd;
  logic                  drive_d;
  logic [DATA_WIDTH-1:0] latch_d;

  always_comb begin
    is_wr   = cs & we & ~oe;
    is_rd   = cs & ~we & oe;
    is_ill  = cs & we & oe;
    drive_d = is_rd;
    latch_d = is_rd ? rd_val : latch_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drive_q <= 1'b0;
      latch_q <= '0;
    end else begin
      drive_q <= drive_d;
      latch_q <= latch_d;
    end
  end
endmodule

module dual_port_reg_file #(
  parameter int DATA_WIDTH   = 8,
  parameter int R_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [R_ADDR_WIDTH-1:0] rr_addr,
  inout  wire  [DATA_WIDTH-1:0]   rr_data,
  input  logic                    rr_cs,
  input  logic                    rr_we,
  input  logic                    rr_oe,
  input  logic [R_ADDR_WIDTH-1:0] rd_addr,
  inout  wire  [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_cs,
  input  logic                    rd_we,
  input  logic                    rd_oe,
  output logic [2*DATA_WIDTH-1:0] z_pointer,
  output logic                    wr_conflict,
  output logic                    illegal_access
);
  localparam int DEPTH     = 2**R_ADDR_WIDTH;
  localparam int NUM_PORTS = 2;  // index 0 = rr, 1 = rd

  logic [NUM_PORTS-1:0]                   cs, we, oe;
  logic [NUM_PORTS-1:0][R_ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   bus_in, rd_val, latch_q;
  logic [NUM_PORTS-1:0]                   is_wr, is_ill, drive_q, bus_en;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [2*DATA_WIDTH-1:0]          zp_q, zp_d;
  logic                             conflict_q, conflict_d;
  logic                             illegal_q, illegal_d;

  assign cs     = {rd_cs, rr_cs};
  assign we     = {rd_we, rr_we};
  assign oe     = {rd_oe, rr_oe};
  assign addr   = {rd_addr, rr_addr};
  assign bus_in = {rd_data, rr_data};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dprf_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs[p]),
      .we      (we[p]),
      .oe      (oe[p]),
      .rd_val  (rd_val[p]),
      .is_wr   (is_wr[p]),
      .is_ill  (is_ill[p]),
      .drive_q (drive_q[p]),
      .latch_q (latch_q[p])
    );
    // Release the bus as soon as the initiator starts driving it, even if the
    // previous cycle was a read whose drive flag has not been cleared yet.
    assign bus_en[p] = drive_q[p] & ~(cs[p] & we[p]);
  end

  assign rr_data = bus_en[0] ? latch_q[0] : 'z;
  assign rd_data = bus_en[1] ? latch_q[1] : 'z;

  always_comb begin
    regs_d = regs_q;
    // rd applied last so it wins a same-address collision.
    if (is_wr[0]) regs_d[addr[0]] = bus_in[0];
    if (is_wr[1]) regs_d[addr[1]] = bus_in[1];
    // Reads see post-write contents: write-first bypass across ports.
    for (int p = 0; p < NUM_PORTS; p++) rd_val[p] = regs_d[addr[p]];
    zp_d       = {regs_d[DEPTH-1], regs_d[DEPTH-2]};
    conflict_d = conflict_q | (is_wr[0] & is_wr[1] & (addr[0] == addr[1]));
    illegal_d  = illegal_q | (|is_ill);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '0;
      zp_q       <= '0;
      conflict_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      zp_q       <= zp_d;
      conflict_q <= conflict_d;
      illegal_q  <= illegal_d;
    end
  end

  assign z_pointer      = zp_q;
  assign wr_conflict    = conflict_q;
  assign illegal_access = illegal_q;
endmodule

// File: tb/tb_dual_port_reg_file.sv
// Directed bench for dual_port_reg_file; buses carry pull-ups so a released bus reads 8'hFF.

module tb_dual_port_reg_file;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rr_addr = '0, rd_addr = '0;
  logic       rr_cs = 0, rr_we = 0, rr_oe = 0;
  logic       rd_cs = 0, rd_we = 0, rd_oe = 0;
  logic [7:0] rr_drv = '0, rd_drv = '0;
  logic       rr_drv_en = 0, rd_drv_en = 0;
  wire  [7:0] rr_data, rd_data;
  logic [15:0] z_pointer;
  logic       wr_conflict, illegal_access;

  int n_vec = 0;
  int n_err = 0;

  assign rr_data = rr_drv_en ? rr_drv : 8'hzz;
  assign rd_data = rd_drv_en ? rd_drv : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (rr_data[i]);
    pullup (rd_data[i]);
  end

  always #5 clk = ~clk;

  dual_port_reg_file dut (
    .clk(clk), .reset(reset),
    .rr_addr(rr_addr), .rr_data(rr_data), .rr_cs(rr_cs), .rr_we(rr_we), .rr_oe(rr_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_cs(rd_cs), .rd_we(rd_we), .rd_oe(rd_oe),
    .z_pointer(z_pointer), .wr_conflict(wr_conflict), .illegal_access(illegal_access)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rr_cs, rr_we, rr_oe, rr_drv_en} = '0;
    {rd_cs, rd_we, rd_oe, rd_drv_en} = '0;
  endtask

  task automatic rr_op(input logic we, input logic oe, input logic [4:0] a, input logic [7:0] d);
    rr_cs = 1; rr_we = we; rr_oe = oe; rr_addr = a; rr_drv = d; rr_drv_en = we;
  endtask

  task automatic rd_op(input logic we, input logic oe, input logic [4:0] a, input logic [7:0] d);
    rd_cs = 1; rd_we = we; rd_oe = oe; rd_addr = a; rd_drv = d; rd_drv_en = we;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    repeat (2) tick();
    n_vec++; if (rr_data !== 8'hFF) begin n_err++; $display("FAIL rst_rr_z got %h want ff", rr_data); end
    n_vec++; if (rd_data !== 8'hFF) begin n_err++; $display("FAIL rst_rd_z got %h want ff", rd_data); end
    n_vec++; if ({z_pointer, wr_conflict, illegal_access} !== 18'h0) begin
      n_err++; $display("FAIL rst_flags got zp=%h c=%b i=%b want 0", z_pointer, wr_conflict, illegal_access);
    end
    reset = 1;
    rr_op(0, 1, 5'd5, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h00) begin n_err++; $display("FAIL rst_read_r5 got %h want 00", rr_data); end
    tick();
    n_vec++; if (rr_data !== 8'hFF) begin n_err++; $display("FAIL rst_read_release got %h want ff", rr_data); end
  endtask

  task automatic test_write_read();
    rd_op(1, 0, 5'd3, 8'hA5);
    tick(); idle();
    rr_op(0, 1, 5'd3, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'hA5) begin n_err++; $display("FAIL wr_rd_r3 got %h want a5", rr_data); end
    tick();
    n_vec++; if (rr_data !== 8'hFF) begin n_err++; $display("FAIL wr_rd_release got %h want ff", rr_data); end
  endtask

  task automatic test_bypass();
    rd_op(1, 0, 5'd7, 8'h3C);
    rr_op(0, 1, 5'd7, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h3C) begin n_err++; $display("FAIL bypass_r7 got %h want 3c", rr_data); end
    rd_op(0, 1, 5'd7, 8'h00);
    tick(); idle();
    n_vec++; if (rd_data !== 8'h3C) begin n_err++; $display("FAIL bypass_readback got %h want 3c", rd_data); end
    tick();
  endtask

  task automatic test_dual_write_back_to_back();
    rr_op(1, 0, 5'd10, 8'h12);
    rd_op(1, 0, 5'd11, 8'h34);
    tick(); idle();
    n_vec++; if (wr_conflict !== 1'b0) begin n_err++; $display("FAIL diff_addr_conflict got %b want 0", wr_conflict); end
    rr_op(0, 1, 5'd10, 8'h00);
    rd_op(0, 1, 5'd11, 8'h00);
    tick();
    n_vec++; if (rr_data !== 8'h12) begin n_err++; $display("FAIL dual_rd_rr got %h want 12", rr_data); end
    n_vec++; if (rd_data !== 8'h34) begin n_err++; $display("FAIL dual_rd_rd got %h want 34", rd_data); end
    rr_op(0, 1, 5'd11, 8'h00);
    rd_op(0, 1, 5'd10, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h34) begin n_err++; $display("FAIL b2b_rr got %h want 34", rr_data); end
    n_vec++; if (rd_data !== 8'h12) begin n_err++; $display("FAIL b2b_rd got %h want 12", rd_data); end
    tick();
  endtask

  task automatic test_conflict_zptr();
    rr_op(1, 0, 5'd30, 8'h11);
    rd_op(1, 0, 5'd30, 8'h22);
    tick(); idle();
    n_vec++; if (wr_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_flag got %b want 1", wr_conflict); end
    n_vec++; if (z_pointer !== 16'h0022) begin n_err++; $display("FAIL conflict_zp got %h want 0022", z_pointer); end
    rd_op(1, 0, 5'd31, 8'h80);
    tick(); idle();
    n_vec++; if (z_pointer !== 16'h8022) begin n_err++; $display("FAIL zp_r31 got %h want 8022", z_pointer); end
    n_vec++; if (wr_conflict !== 1'b1) begin n_err++; $display("FAIL conflict_sticky got %b want 1", wr_conflict); end
    rr_op(0, 1, 5'd30, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h22) begin n_err++; $display("FAIL conflict_r30 got %h want 22", rr_data); end
    tick();
  endtask

  task automatic test_illegal();
    rr_cs = 1; rr_we = 1; rr_oe = 1; rr_addr = 5'd4; rr_drv = 8'hFF; rr_drv_en = 1;
    tick(); idle();
    n_vec++; if (illegal_access !== 1'b1) begin n_err++; $display("FAIL illegal_flag got %b want 1", illegal_access); end
    n_vec++; if (rr_data !== 8'hFF) begin n_err++; $display("FAIL illegal_bus_z got %h want ff", rr_data); end
    rr_op(0, 1, 5'd4, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h00) begin n_err++; $display("FAIL illegal_r4 got %h want 00", rr_data); end
    tick();
    n_vec++; if (illegal_access !== 1'b1) begin n_err++; $display("FAIL illegal_sticky got %b want 1", illegal_access); end
  endtask

  task automatic test_reset_mid_read();
    rr_op(0, 1, 5'd3, 8'h00);
    tick();
    n_vec++; if (rr_data !== 8'hA5) begin n_err++; $display("FAIL mid_pre got %h want a5", rr_data); end
    #2 reset = 0;
    #1;
    n_vec++; if (rr_data !== 8'hFF) begin n_err++; $display("FAIL mid_rst_z got %h want ff", rr_data); end
    n_vec++; if ({z_pointer, wr_conflict, illegal_access} !== 18'h0) begin
      n_err++; $display("FAIL mid_rst_flags got zp=%h c=%b i=%b want 0", z_pointer, wr_conflict, illegal_access);
    end
    idle();
    tick(); reset = 1;
    rr_op(0, 1, 5'd3, 8'h00);
    rd_op(0, 1, 5'd31, 8'h00);
    tick(); idle();
    n_vec++; if (rr_data !== 8'h00) begin n_err++; $display("FAIL post_rst_r3 got %h want 00", rr_data); end
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL post_rst_r31 got %h want 00", rd_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_dual_write_back_to_back();
    test_conflict_zptr();
    test_illegal();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
